// File: rtl/csa_mac_resolver.sv
// csa_mac_resolver: resolves a carry-save (sum, carry) pair into a
// two's-complement product CHUNK bits per cycle, LSB first, and either loads
// it into or adds it to a wide accumulator with sticky signed overflow.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Input side: in_valid/in_ready, in_ready is high only in IDLE.
// Output side: out_valid/out_ready, out_valid is high only in DONE and
// out_data is held until the transfer.
module csa_mac_resolver #(
    parameter int W     = 34,
    parameter int ACC_W = 51,
    parameter int CHUNK = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     in_sum,
    input  logic [W-1:0]     in_carry,
    input  logic             in_acc,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             acc_clr,
    output logic [1:0]       o_dbg_state
);

    localparam int NP = W / CHUNK;      // chunks carrying product bits
    localparam int NA = ACC_W / CHUNK;  // chunks per accumulator pass
    localparam int KW = (NA > 1) ? $clog2(NA) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NA - 1);
    localparam logic [KW-1:0] K_SIGN = KW'(NP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [W-1:0]       r_sum;      // shifted right one chunk per RUN cycle
    logic [W-1:0]       r_carry;
    logic               r_acc_en;
    logic               r_pc;       // product carry between chunks
    logic               r_ac;       // accumulator carry between chunks
    logic [KW-1:0]      r_k;
    logic               r_sign;     // product sign once chunk NP-1 resolved
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;

    logic               w_in_prod;
    logic [CHUNK:0]     w_p;
    logic               w_sign;
    logic [CHUNK-1:0]   w_pchunk;
    logic [CHUNK-1:0]   w_acc_op;
    logic [CHUNK:0]     w_a;
    logic               w_ovf_hit;

    // Per-chunk product resolution, sign extension and accumulate add.
    always_comb begin
        w_in_prod = (int'(r_k) < NP);
        w_p       = {1'b0, r_sum[CHUNK-1:0]} + {1'b0, r_carry[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, r_pc};
        // The product sign is the MSB of the last product chunk; the carry
        // out of that chunk is dropped so the product wraps mod 2^W.
        w_sign    = (r_k == K_SIGN) ? w_p[CHUNK-1] : r_sign;
        w_pchunk  = w_in_prod ? w_p[CHUNK-1:0] : {CHUNK{r_sign}};
        w_acc_op  = r_acc_en ? r_acc[int'(r_k)*CHUNK +: CHUNK] : '0;
        w_a       = {1'b0, w_acc_op} + {1'b0, w_pchunk} + {{CHUNK{1'b0}}, r_ac};
        // Only meaningful on the final chunk: the product's top chunk MSB is
        // always its sign, so compare that against the accumulator MSB.
        w_ovf_hit = (w_acc_op[CHUNK-1] == w_sign) && (w_a[CHUNK-1] != w_sign);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_RUN;
            end
            S_RUN: begin
                if (r_k == K_LAST) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, chunk-serial datapath and accumulator clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum    <= '0;
            r_carry  <= '0;
            r_acc_en <= 1'b0;
            r_pc     <= 1'b0;
            r_ac     <= 1'b0;
            r_k      <= '0;
            r_sign   <= 1'b0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sum    <= in_sum;
                        r_carry  <= in_carry;
                        r_acc_en <= in_acc;
                        r_pc     <= 1'b0;
                        r_ac     <= 1'b0;
                        r_k      <= '0;
                        r_sign   <= 1'b0;
                    end else if (acc_clr) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_sum   <= r_sum >> CHUNK;
                    r_carry <= r_carry >> CHUNK;
                    r_pc    <= w_in_prod ? w_p[CHUNK] : 1'b0;
                    r_sign  <= w_sign;
                    r_acc[int'(r_k)*CHUNK +: CHUNK] <= w_a[CHUNK-1:0];
                    r_ac    <= w_a[CHUNK];
                    if (r_k == K_LAST) begin
                        r_k <= '0;
                        if (w_ovf_hit) r_ovf <= 1'b1;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data    = r_acc;
    assign out_ovf     = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_csa_mac_resolver.sv
// Bench for csa_mac_resolver. A default-size instance is driven with directed
// and random pairs and checked by a scoreboard; a small-parameter instance
// reaches the accumulator overflow boundary in a handful of operations.
module tb_csa_mac_resolver;

    localparam int W     = 34;
    localparam int ACC_W = 51;
    localparam int CHUNK = 17;
    localparam int SW    = 8;
    localparam int SAW   = 12;
    localparam int SCH   = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance ----------------
    logic [W-1:0]     in_sum = '0;
    logic [W-1:0]     in_carry = '0;
    logic             in_acc = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             acc_clr = 1'b0;
    logic [1:0]       dbg_state;

    csa_mac_resolver #(.W(W), .ACC_W(ACC_W), .CHUNK(CHUNK)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_sum(in_sum), .in_carry(in_carry), .in_acc(in_acc),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ovf(out_ovf),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_clr(acc_clr), .o_dbg_state(dbg_state)
    );

    // ---------------- small instance ----------------
    logic [SW-1:0]  s_in_sum = '0;
    logic [SW-1:0]  s_in_carry = '0;
    logic           s_in_acc = 1'b0;
    logic           s_in_valid = 1'b0;
    logic           s_in_ready;
    logic [SAW-1:0] s_out_data;
    logic           s_out_ovf;
    logic           s_out_valid;
    logic           s_out_ready = 1'b1;
    logic           s_acc_clr = 1'b0;
    logic [1:0]     s_dbg_state;

    csa_mac_resolver #(.W(SW), .ACC_W(SAW), .CHUNK(SCH)) u_small (
        .clk(clk), .rst_n(rst_n),
        .in_sum(s_in_sum), .in_carry(s_in_carry), .in_acc(s_in_acc),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_ovf(s_out_ovf),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .acc_clr(s_acc_clr), .o_dbg_state(s_dbg_state)
    );

    // ---------------- bookkeeping / model state ----------------
    int               n_tests = 0;
    int               n_fail = 0;
    logic [ACC_W:0]   exp_q[$];     // {ovf, data} per accepted pair
    logic [ACC_W:0]   m_exp;
    logic [ACC_W-1:0] m_acc = '0;
    logic             m_ovf = 1'b0;
    logic [63:0]      ms_acc = '0;
    logic             ms_ovf = 1'b0;
    bit               rdy_rand = 1'b0;

    // Reference MAC: full-width modular arithmetic on integers.
    // Returns {sticky_ovf, new_acc}.
    function automatic logic [64:0] mac_model(input logic [63:0] acc,
                                              input logic [63:0] s,
                                              input logic [63:0] c,
                                              input logic a,
                                              input logic ovf_in,
                                              input int w,
                                              input int aw);
        logic [63:0] mw, maw, pe, op, res;
        logic        ov;
        mw  = (64'd1 << w) - 64'd1;
        maw = (64'd1 << aw) - 64'd1;
        pe  = (s + c) & mw;
        if (pe[w-1]) pe = pe | (maw & ~mw);
        op  = a ? (acc & maw) : 64'd0;
        res = (op + pe) & maw;
        ov  = ovf_in | ((op[aw-1] == pe[aw-1]) && (res[aw-1] != op[aw-1]));
        return {ov, res};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL result: unexpected output data=%0h ovf=%0b", out_data, out_ovf);
            end else begin
                m_exp = exp_q.pop_front();
                if ({out_ovf, out_data} !== m_exp) begin
                    n_fail++;
                    $display("FAIL result: got ovf=%0b data=%0h expected ovf=%0b data=%0h",
                             out_ovf, out_data, m_exp[ACC_W], m_exp[ACC_W-1:0]);
                end
            end
        end
    end

    // Random downstream backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_main_ready();
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (in_ready) return;
        end
        check("in_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic issue(input logic [W-1:0] s, input logic [W-1:0] c,
                         input logic a, input logic clr, input bit chk_lat);
        logic [64:0] r;
        int          lat;
        wait_main_ready();
        in_sum   = s;
        in_carry = c;
        in_acc   = a;
        acc_clr  = clr;      // capture takes priority over a clear
        in_valid = 1'b1;
        r = mac_model(64'(m_acc), 64'(s), 64'(c), a, m_ovf, W, ACC_W);
        m_acc = r[ACC_W-1:0];
        m_ovf = r[64];
        exp_q.push_back({m_ovf, m_acc});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        in_sum   = W'({$urandom, $urandom});
        in_carry = W'({$urandom, $urandom});
        in_acc   = 1'($urandom_range(0, 1));
        if (chk_lat) begin
            // Count rising edges from the capture edge (inclusive) to the
            // edge on which out_valid rises.
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("latency", 64'(lat), 64'd4);
        end
    endtask

    task automatic do_clear();
        wait_main_ready();
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        m_acc = '0;
        m_ovf = 1'b0;
        check("clr_data", 64'(out_data), 64'd0);
        check("clr_ovf", 64'(out_ovf), 64'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic small_op(input logic [SW-1:0] s, input logic [SW-1:0] c, input logic a);
        logic [64:0] r;
        int          n;
        n = 0;
        while (!s_in_ready && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        s_in_sum   = s;
        s_in_carry = c;
        s_in_acc   = a;
        s_in_valid = 1'b1;
        r = mac_model(ms_acc, 64'(s), 64'(c), a, ms_ovf, SW, SAW);
        ms_acc = r[63:0];
        ms_ovf = r[64];
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        n = 0;
        while (!s_out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("s_data", 64'(s_out_data), ms_acc);
        check("s_ovf", 64'(s_out_ovf), 64'(ms_ovf));
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] rs, rc;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Directed cases.
        issue(34'd5, 34'd10, 1'b0, 1'b0, 1'b1);            // 15
        issue(34'd5, 34'h3_FFFF_FFEC, 1'b0, 1'b0, 1'b1);   // -15
        issue(34'd20, 34'd0, 1'b1, 1'b0, 1'b1);            // -15 + 20 = 5
        do_clear();
        issue(34'd7, 34'd0, 1'b1, 1'b0, 1'b1);             // 7
        issue(34'h1FFFF, 34'd1, 1'b0, 1'b0, 1'b1);         // 0x20000
        issue(34'd3, 34'd0, 1'b1, 1'b1, 1'b1);             // clear ignored
        issue(34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
        drain();

        // Backpressure: result held, new pair not taken.
        wait_main_ready();
        out_ready = 1'b0;
        issue(34'd11, 34'd22, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_sum   = 34'd100;
        in_carry = 34'd0;
        in_acc   = 1'b0;
        m_exp = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_data", 64'(out_data), 64'(m_exp[ACC_W-1:0]));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_after_in_ready", 64'(in_ready), 64'd1);
        check("bp_after_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("bp_no_capture", 64'(in_ready), 64'd1);
        drain();

        // Random pairs with random backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) do_clear();
            rs = W'({$urandom, $urandom});
            rc = W'({$urandom, $urandom});
            issue(rs, rc, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end
        drain();
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Reset in the middle of RUN.
        issue(34'd9, 34'd9, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        check("mid_rst_out_ovf", 64'(out_ovf), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        m_acc  = '0;
        m_ovf  = 1'b0;
        ms_acc = '0;
        ms_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        issue(34'd4, 34'd4, 1'b1, 1'b0, 1'b1);             // 8 from cleared acc
        drain();

        // Overflow boundary on the small instance (ACC max = 2^11-1).
        small_op(8'd127, 8'd0, 1'b0);
        for (int i = 0; i < 15; i++) small_op(8'd127, 8'd0, 1'b1);
        small_op(8'd15, 8'd0, 1'b1);                       // 2047
        check("s_max_no_ovf", 64'(s_out_ovf), 64'd0);
        small_op(8'd1, 8'd0, 1'b1);                        // wraps to 0x800
        check("s_wrap_data", 64'(s_out_data), 64'h800);
        check("s_wrap_ovf", 64'(s_out_ovf), 64'd1);
        small_op(8'd1, 8'd0, 1'b1);                        // ovf sticky
        s_acc_clr = 1'b1;
        @(posedge clk);
        #1;
        s_acc_clr = 1'b0;
        ms_acc = '0;
        ms_ovf = 1'b0;
        check("s_clr_ovf", 64'(s_out_ovf), 64'd0);
        check("s_clr_data", 64'(s_out_data), 64'd0);
        small_op(8'h80, 8'd0, 1'b1);                       // -128 sign-extended
        small_op(8'hF0, 8'h20, 1'b0);                      // carry out of W dropped

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
